// File: rtl/ddr4_cmd_pkg.sv
// Shared types for the DDR4 command decoder.
//   pwr_state_t : CKE power state, encoded to match the pwr_state output
//   cmd_t       : command class derived from cs_n/act_n/ras_n/cas_n/we_n
//   MR3_BG/BA   : bank address of mode register 3 (holds the MPR enable bit)
package ddr4_cmd_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ACTIVE = 2'd1,
    PDN    = 2'd2,
    SREF   = 2'd3
  } pwr_state_t;

  // CMD_ prefix keeps these literals apart from the ACT/REF/WR/RD port names.
  typedef enum logic [3:0] {
    CMD_DES,
    CMD_NOP,
    CMD_ACT,
    CMD_MRS,
    CMD_REF,
    CMD_PRE,
    CMD_WR,
    CMD_RD,
    CMD_ZQ,
    CMD_RFU
  } cmd_t;

  localparam int MR3_BG = 0;
  localparam int MR3_BA = 3;

  // Deselect and NOP are the only encodings tolerated while CKE is low.
  function automatic logic is_quiet(input cmd_t c);
    return (c == CMD_DES) || (c == CMD_NOP);
  endfunction

endpackage

// File: rtl/ddr4_cmd_decoder_pin_decode.sv
// Purely combinational classifier: control pins -> cmd_t.
// Ports:
//   cs_n, act_n, ras_n, cas_n, we_n : raw command pins (active low)
//   cmd                             : command class for this cycle
module ddr4_cmd_decoder_pin_decode
  import ddr4_cmd_pkg::*;
(
  input  logic cs_n,
  input  logic act_n,
  input  logic ras_n,
  input  logic cas_n,
  input  logic we_n,
  output cmd_t cmd
);

  always_comb begin
    cmd = CMD_NOP;
    if (cs_n) begin
      cmd = CMD_DES;
    end else if (!act_n) begin
      // ras_n/cas_n/we_n are row address bits A16..A14 during ACT
      cmd = CMD_ACT;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b000:  cmd = CMD_MRS;
        3'b001:  cmd = CMD_REF;
        3'b010:  cmd = CMD_PRE;
        3'b011:  cmd = CMD_RFU;
        3'b100:  cmd = CMD_WR;
        3'b101:  cmd = CMD_RD;
        3'b110:  cmd = CMD_ZQ;
        default: cmd = CMD_NOP;
      endcase
    end
  end

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command front end: samples the command/address pins each clock and
// produces registered one-cycle command strobes (per bank where the command
// addresses a bank), tracks CKE power state and MPR mode, and flags illegal
// commands.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   cke, cs_n, act_n, ras_n,
//   cas_n, we_n, bg, ba, addr  : DDR4 command/address pins
//   ACT/RD/RDA/WR/WRA/PR       : per-bank one-hot strobes (NB wide)
//   PRA/REF/SRF/PD/PDX/CKEH/
//   CKEL/MRW/MRR               : broadcast strobes
//   bank_idx, row_addr,
//   col_addr                   : addresses latched with the bank commands
//   mpr_mode                   : MR3 A2 shadow
//   err_illegal                : illegal-command strobe
//   pwr_state                  : INIT/ACTIVE/PDN/SREF
//
// state  | meaning
// INIT   | after reset, waiting for the first cke=1; commands ignored
// ACTIVE | CKE high, commands decoded
// PDN    | power-down, waiting for cke=1
// SREF   | self-refresh, waiting for cke=1
module ddr4_cmd_decoder
  import ddr4_cmd_pkg::*;
#(
  parameter int BGW = 2,
  parameter int BAW = 2,
  parameter int AW  = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cke,
  input  logic                      cs_n,
  input  logic                      act_n,
  input  logic                      ras_n,
  input  logic                      cas_n,
  input  logic                      we_n,
  input  logic [BGW-1:0]            bg,
  input  logic [BAW-1:0]            ba,
  input  logic [AW-1:0]             addr,
  output logic [2**(BGW+BAW)-1:0]   ACT,
  output logic [2**(BGW+BAW)-1:0]   RD,
  output logic [2**(BGW+BAW)-1:0]   RDA,
  output logic [2**(BGW+BAW)-1:0]   WR,
  output logic [2**(BGW+BAW)-1:0]   WRA,
  output logic [2**(BGW+BAW)-1:0]   PR,
  output logic                      PRA,
  output logic                      REF,
  output logic                      SRF,
  output logic                      PD,
  output logic                      PDX,
  output logic                      CKEH,
  output logic                      CKEL,
  output logic                      MRW,
  output logic                      MRR,
  output logic [BGW+BAW-1:0]        bank_idx,
  output logic [AW:0]               row_addr,
  output logic [AW-1:0]             col_addr,
  output logic                      mpr_mode,
  output logic                      err_illegal,
  output logic [1:0]                pwr_state
);

  localparam int BW = BGW + BAW;
  localparam int NB = 2 ** BW;

  cmd_t       cmd;
  pwr_state_t state_q, state_d;
  logic       cke_q;

  logic [BW-1:0] bank;
  logic [NB-1:0] bank_oh;
  logic [AW:0]   row_pins;
  logic          is_mr3;

  logic [NB-1:0] act_d, rd_d, rda_d, wr_d, wra_d, pr_d;
  logic          pra_d, refr_d, srf_d, pd_d, pdx_d, ckeh_d, ckel_d;
  logic          mrw_d, mrr_d, err_d, mpr_d;
  logic [BW-1:0] bank_d;
  logic [AW:0]   row_d;
  logic [AW-1:0] col_d;

  ddr4_cmd_decoder_pin_decode u_pin_decode (
    .cs_n  (cs_n),
    .act_n (act_n),
    .ras_n (ras_n),
    .cas_n (cas_n),
    .we_n  (we_n),
    .cmd   (cmd)
  );

  assign bank      = {bg, ba};
  assign is_mr3    = (bg == BGW'(MR3_BG)) && (ba == BAW'(MR3_BA));
  assign pwr_state = state_q;

  always_comb begin
    bank_oh       = '0;
    bank_oh[bank] = 1'b1;
  end

  // Row is A16..A14 (carried on ras_n/cas_n/we_n) plus A13..A0; anything
  // above A16 in a wider configuration reads as zero.
  always_comb begin
    row_pins       = '0;
    row_pins[16:0] = {ras_n, cas_n, we_n, addr[13:0]};
  end

  always_comb begin
    state_d = state_q;
    act_d   = '0;
    rd_d    = '0;
    rda_d   = '0;
    wr_d    = '0;
    wra_d   = '0;
    pr_d    = '0;
    pra_d   = 1'b0;
    refr_d  = 1'b0;
    srf_d   = 1'b0;
    pd_d    = 1'b0;
    pdx_d   = 1'b0;
    ckeh_d  = 1'b0;
    ckel_d  = 1'b0;
    mrw_d   = 1'b0;
    mrr_d   = 1'b0;
    err_d   = 1'b0;
    mpr_d   = mpr_mode;
    bank_d  = bank_idx;
    row_d   = row_addr;
    col_d   = col_addr;

    case (state_q)
      INIT: begin
        if (cke) state_d = ACTIVE;
      end

      ACTIVE: begin
        if (cke_q && !cke) begin
          // CKE falling: only DES/NOP (power-down) or REF (self-refresh)
          if (is_quiet(cmd)) begin
            state_d = PDN;
            pd_d    = 1'b1;
            ckel_d  = 1'b1;
          end else if (cmd == CMD_REF) begin
            state_d = SREF;
            srf_d   = 1'b1;
            ckel_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (cke_q && cke) begin
          case (cmd)
            CMD_ACT: begin
              act_d  = bank_oh;
              bank_d = bank;
              row_d  = row_pins;
            end
            CMD_MRS: begin
              mrw_d = 1'b1;
              if (is_mr3) mpr_d = addr[2];
            end
            CMD_REF: refr_d = 1'b1;
            CMD_PRE: begin
              if (addr[10]) begin
                pra_d = 1'b1;
              end else begin
                pr_d   = bank_oh;
                bank_d = bank;
              end
            end
            CMD_WR: begin
              if (addr[10]) wra_d = bank_oh;
              else          wr_d  = bank_oh;
              bank_d = bank;
              col_d  = addr;
            end
            CMD_RD: begin
              col_d = addr;
              // In MPR mode a read targets the MPR page, not a bank.
              if (mpr_mode) begin
                mrr_d = 1'b1;
              end else begin
                if (addr[10]) rda_d = bank_oh;
                else          rd_d  = bank_oh;
                bank_d = bank;
              end
            end
            CMD_RFU: err_d = 1'b1;
            default: ;
          endcase
        end
      end

      PDN, SREF: begin
        if (!is_quiet(cmd)) err_d = 1'b1;
        if (cke) begin
          state_d = ACTIVE;
          ckeh_d  = 1'b1;
          pdx_d   = (state_q == PDN);
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cke_q       <= 1'b0;
      ACT         <= '0;
      RD          <= '0;
      RDA         <= '0;
      WR          <= '0;
      WRA         <= '0;
      PR          <= '0;
      PRA         <= 1'b0;
      REF         <= 1'b0;
      SRF         <= 1'b0;
      PD          <= 1'b0;
      PDX         <= 1'b0;
      CKEH        <= 1'b0;
      CKEL        <= 1'b0;
      MRW         <= 1'b0;
      MRR         <= 1'b0;
      err_illegal <= 1'b0;
      mpr_mode    <= 1'b0;
      bank_idx    <= '0;
      row_addr    <= '0;
      col_addr    <= '0;
    end else begin
      state_q     <= state_d;
      cke_q       <= cke;
      ACT         <= act_d;
      RD          <= rd_d;
      RDA         <= rda_d;
      WR          <= wr_d;
      WRA         <= wra_d;
      PR          <= pr_d;
      PRA         <= pra_d;
      REF         <= refr_d;
      SRF         <= srf_d;
      PD          <= pd_d;
      PDX         <= pdx_d;
      CKEH        <= ckeh_d;
      CKEL        <= ckel_d;
      MRW         <= mrw_d;
      MRR         <= mrr_d;
      err_illegal <= err_d;
      mpr_mode    <= mpr_d;
      bank_idx    <= bank_d;
      row_addr    <= row_d;
      col_addr    <= col_d;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Bench for ddr4_cmd_decoder: directed command sequences followed by random
// pin traffic, every cycle compared against a behavioural reference model.
module tb_ddr4_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [1:0]  bg, ba;
  logic [16:0] addr;
  logic [15:0] ACT, RD, RDA, WR, WRA, PR;
  logic        PRA, REF, SRF, PD, PDX, CKEH, CKEL, MRW, MRR;
  logic [3:0]  bank_idx;
  logic [17:0] row_addr;
  logic [16:0] col_addr;
  logic        mpr_mode, err_illegal;
  logic [1:0]  pwr_state;

  always #5 clk = ~clk;

  ddr4_cmd_decoder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg(bg), .ba(ba), .addr(addr),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR),
    .PRA(PRA), .REF(REF), .SRF(SRF), .PD(PD), .PDX(PDX), .CKEH(CKEH),
    .CKEL(CKEL), .MRW(MRW), .MRR(MRR), .bank_idx(bank_idx),
    .row_addr(row_addr), .col_addr(col_addr), .mpr_mode(mpr_mode),
    .err_illegal(err_illegal), .pwr_state(pwr_state)
  );

  int errors = 0;
  int checks = 0;

  // command kinds as the model sees them
  localparam int K_DES = 0, K_NOP = 1, K_ACT = 2, K_MRS = 3, K_REF = 4,
                 K_PRE = 5, K_WR = 6, K_RD = 7, K_ZQ = 8, K_RFU = 9;
  // bit positions within the broadcast-flag vector
  localparam int F_PRA = 9, F_REF = 8, F_SRF = 7, F_PD = 6, F_PDX = 5,
                 F_CKEH = 4, F_CKEL = 3, F_MRW = 2, F_MRR = 1, F_ERR = 0;

  // model state: 0 INIT, 1 ACTIVE, 2 power-down, 3 self-refresh
  int        m_state = 0;
  bit        m_ckeq = 0;
  bit        m_mpr = 0;
  int        m_bank = 0;
  int        m_row = 0;
  int        m_col = 0;
  bit [15:0] e_act, e_rd, e_rda, e_wr, e_wra, e_pr;
  bit [9:0]  e_flags;

  function automatic int kind(bit csn, bit actn, bit rn, bit cn, bit wn);
    int code;
    if (csn) return K_DES;
    if (!actn) return K_ACT;
    code = rn * 4 + cn * 2 + wn;
    case (code)
      0: return K_MRS;
      1: return K_REF;
      2: return K_PRE;
      3: return K_RFU;
      4: return K_WR;
      5: return K_RD;
      6: return K_ZQ;
      default: return K_NOP;
    endcase
  endfunction

  task automatic model(input bit r, ck, csn, actn, rn, cn, wn,
                       input bit [1:0] g, b, input bit [16:0] a);
    int k, bk, nxt;
    bit a10;
    e_act = '0; e_rd = '0; e_rda = '0; e_wr = '0; e_wra = '0; e_pr = '0;
    e_flags = '0;
    if (r) begin
      m_state = 0; m_ckeq = 0; m_mpr = 0; m_bank = 0; m_row = 0; m_col = 0;
      return;
    end
    k   = kind(csn, actn, rn, cn, wn);
    bk  = g * 4 + b;
    a10 = (a / 1024) % 2;
    nxt = m_state;
    if (m_state == 0) begin
      if (ck) nxt = 1;
    end else if (m_state == 1) begin
      if (m_ckeq && !ck) begin
        if (k == K_DES || k == K_NOP) begin
          nxt = 2; e_flags[F_PD] = 1; e_flags[F_CKEL] = 1;
        end else if (k == K_REF) begin
          nxt = 3; e_flags[F_SRF] = 1; e_flags[F_CKEL] = 1;
        end else e_flags[F_ERR] = 1;
      end else if (m_ckeq && ck) begin
        case (k)
          K_ACT: begin
            e_act[bk] = 1; m_bank = bk;
            m_row = rn * 65536 + cn * 32768 + wn * 16384 + (a % 16384);
          end
          K_MRS: begin
            e_flags[F_MRW] = 1;
            if (g == 0 && b == 3) m_mpr = (a / 4) % 2;
          end
          K_REF: e_flags[F_REF] = 1;
          K_PRE: if (a10) e_flags[F_PRA] = 1;
                 else begin e_pr[bk] = 1; m_bank = bk; end
          K_WR: begin
            if (a10) e_wra[bk] = 1; else e_wr[bk] = 1;
            m_bank = bk; m_col = a;
          end
          K_RD: begin
            m_col = a;
            if (m_mpr) e_flags[F_MRR] = 1;
            else begin
              if (a10) e_rda[bk] = 1; else e_rd[bk] = 1;
              m_bank = bk;
            end
          end
          K_RFU: e_flags[F_ERR] = 1;
          default: ;
        endcase
      end
    end else begin
      if (k != K_DES && k != K_NOP) e_flags[F_ERR] = 1;
      if (ck) begin
        e_flags[F_CKEH] = 1;
        if (m_state == 2) e_flags[F_PDX] = 1;
        nxt = 1;
      end
    end
    m_state = nxt;
    m_ckeq  = ck;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, ck, csn, actn, rn, cn, wn,
                      input bit [1:0] g, b, input bit [16:0] a);
    rst = r; cke = ck; cs_n = csn; act_n = actn;
    ras_n = rn; cas_n = cn; we_n = wn; bg = g; ba = b; addr = a;
    model(r, ck, csn, actn, rn, cn, wn, g, b, a);
    @(posedge clk);
    #1;
    check("ACT", 32'(ACT), 32'(e_act));
    check("RD", 32'(RD), 32'(e_rd));
    check("RDA", 32'(RDA), 32'(e_rda));
    check("WR", 32'(WR), 32'(e_wr));
    check("WRA", 32'(WRA), 32'(e_wra));
    check("PR", 32'(PR), 32'(e_pr));
    check("flags", 32'({PRA, REF, SRF, PD, PDX, CKEH, CKEL, MRW, MRR, err_illegal}),
          32'(e_flags));
    check("bank_idx", 32'(bank_idx), m_bank);
    check("row_addr", 32'(row_addr), m_row);
    check("col_addr", 32'(col_addr), m_col);
    check("mpr_mode", 32'(mpr_mode), 32'(m_mpr));
    check("pwr_state", 32'(pwr_state), m_state);
  endtask

  // command with cs_n=0; rcw = {ras_n,cas_n,we_n}
  task automatic cmd(input bit ck, actn, input bit [2:0] rcw,
                     input bit [1:0] g, b, input bit [16:0] a);
    step(0, ck, 0, actn, rcw[2], rcw[1], rcw[0], g, b, a);
  endtask

  task automatic des(input bit ck);
    step(0, ck, 1, 1, 1, 1, 1, 2'd0, 2'd0, 17'd0);
  endtask

  initial begin
    step(1, 0, 1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 1, 1, 1, 0, 0, 0);
    check("rst_pwr", 32'(pwr_state), 0);

    cmd(1, 1, 3'b111, 0, 0, 0);                 // INIT -> ACTIVE
    check("init_exit_pwr", 32'(pwr_state), 1);

    cmd(1, 0, 3'b000, 2'd1, 2'd2, 17'h0123);    // ACT bank 6
    check("act_bank6", 32'(ACT), 32'h0040);
    check("act_idx", 32'(bank_idx), 6);
    check("act_row", 32'(row_addr[13:0]), 32'h0123);

    cmd(1, 1, 3'b100, 2'd0, 2'd3, 17'h0415);    // WRA bank 3
    check("wra_bank3", 32'(WRA), 32'h0008);
    check("wra_col", 32'(col_addr), 32'h0415);
    cmd(1, 1, 3'b101, 2'd0, 2'd3, 17'h0022);    // RD bank 3
    check("rd_bank3", 32'(RD), 32'h0008);
    check("rd_col", 32'(col_addr), 32'h0022);

    cmd(1, 1, 3'b010, 2'd1, 2'd1, 17'h0400);    // PRA
    check("pra", 32'(PRA), 1);
    check("pra_no_pr", 32'(PR), 0);
    cmd(1, 1, 3'b010, 2'd3, 2'd3, 17'h0000);    // PR bank 15
    check("pr_bank15", 32'(PR), 32'h8000);

    des(0);                                     // power-down entry
    check("pd", 32'({PD, CKEL}), 32'b11);
    for (int i = 0; i < 10; i++) des(0);
    des(1);                                     // power-down exit
    check("pdx", 32'({PDX, CKEH}), 32'b11);
    check("pdx_pwr", 32'(pwr_state), 1);

    cmd(0, 1, 3'b001, 0, 0, 0);                 // self-refresh entry
    check("srf", 32'({SRF, CKEL, REF}), 32'b110);
    for (int i = 0; i < 10; i++) des(0);
    des(1);
    check("sref_exit", 32'({PDX, CKEH}), 32'b01);

    cmd(1, 1, 3'b000, 2'd0, 2'd3, 17'h0004);    // MR3 A2=1
    check("mpr_set", 32'(mpr_mode), 1);
    cmd(1, 1, 3'b101, 2'd1, 2'd1, 17'h0010);
    check("mrr", 32'({MRR, |RD, |RDA}), 32'b100);
    cmd(1, 1, 3'b000, 2'd0, 2'd3, 17'h0000);    // MR3 A2=0
    cmd(1, 1, 3'b101, 2'd1, 2'd1, 17'h0010);
    check("rd_after_mpr", 32'(RD), 32'h0020);

    cmd(1, 1, 3'b011, 0, 0, 0);                 // RFU
    check("rfu_err", 32'(err_illegal), 1);
    des(0);
    cmd(0, 0, 3'b000, 2'd2, 2'd2, 17'h0055);    // ACT while powered down
    check("pdn_act_err", 32'(err_illegal), 1);
    check("pdn_act_none", 32'(ACT), 0);
    des(1);
    cmd(1, 0, 3'b000, 2'd2, 2'd1, 17'h0077);
    check("act_before_rst", 32'(ACT), 32'h0200);
    step(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
    check("rst_clears_act", 32'(ACT), 0);
    check("rst_pwr_init", 32'(pwr_state), 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 2'($urandom), 17'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
